// File: rtl/word_unpacker.sv
// Reads a run of MEM_WORD_SIZE-bit memory words and presents each one to a consumer as two DATA_W halves.
// Optional build macro WORD_UNPACKER_HI_FIRST_EN: when defined, the high half of each word is sent first.
module word_unpacker #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int ADDR_W        = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        start_addr_i,
  input  logic [ADDR_W-1:0]        end_addr_i,
  output logic                     mem_re_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     loc_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND_FIRST,
    S_SEND_SECOND,
    S_DONE
  } state_t;

`ifdef WORD_UNPACKER_HI_FIRST_EN
  localparam logic FIRST_LOC = 1'b1;
`else
  localparam logic FIRST_LOC = 1'b0;
`endif

  state_t                   r_state;
  logic [ADDR_W-1:0]        r_cur_addr;
  logic [ADDR_W-1:0]        r_last_addr;
  logic [MEM_WORD_SIZE-1:0] r_word;
  logic                     r_mem_re;
  logic [ADDR_W-1:0]        r_mem_addr;
  logic [DATA_W-1:0]        r_data;
  logic                     r_loc;
  logic                     r_valid;
  logic                     r_done;

  logic [ADDR_W-1:0]        w_next_addr;

  function automatic logic [DATA_W-1:0] half_sel(input logic [MEM_WORD_SIZE-1:0] word,
                                                 input logic                     loc);
    return loc ? word[MEM_WORD_SIZE-1:DATA_W] : word[DATA_W-1:0];
  endfunction

  // Plain binary add wraps through the top address, so runs with start > end need no special case.
  assign w_next_addr = r_cur_addr + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_last_addr <= '0;
      r_word      <= '0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_data      <= '0;
      r_loc       <= 1'b0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment; the pulse outputs default low here
      // so every state only has to name the cycle in which a pulse is raised.
      r_mem_re   <= 1'b0;
      r_mem_addr <= '0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_cur_addr  <= start_addr_i;
            r_last_addr <= end_addr_i;
            r_mem_re    <= 1'b1;
            r_mem_addr  <= start_addr_i;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_word  <= mem_rdata_i;
          r_data  <= half_sel(mem_rdata_i, FIRST_LOC);
          r_loc   <= FIRST_LOC;
          r_valid <= 1'b1;
          r_state <= S_SEND_FIRST;
        end
        S_SEND_FIRST: begin
          if (ready_i) begin
            r_data  <= half_sel(r_word, ~r_loc);
            r_loc   <= ~r_loc;
            r_state <= S_SEND_SECOND;
          end
        end
        S_SEND_SECOND: begin
          if (ready_i) begin
            r_data  <= '0;
            r_loc   <= 1'b0;
            r_valid <= 1'b0;
            if (r_cur_addr == r_last_addr) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cur_addr <= w_next_addr;
              r_mem_re   <= 1'b1;
              r_mem_addr <= w_next_addr;
              r_state    <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_re_o   = r_mem_re;
  assign mem_addr_o = r_mem_addr;
  assign data_o     = r_data;
  assign loc_o      = r_loc;
  assign valid_o    = r_valid;
  assign done_o     = r_done;
  assign busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_word_unpacker.sv
// Directed self-checking bench for word_unpacker with a small behavioural memory and transfer monitor.
// Mirrors the WORD_UNPACKER_HI_FIRST_EN build macro to pick the expected half order.
module tb_word_unpacker;

  localparam int DATA_W = 32;
  localparam int MEM_W  = 64;
  localparam int ADDR_W = 10;

`ifdef WORD_UNPACKER_HI_FIRST_EN
  localparam bit HI_FIRST = 1'b1;
`else
  localparam bit HI_FIRST = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_rdata;
  logic [DATA_W-1:0] data;
  logic              loc;
  logic              valid;
  logic              ready;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_errors = 0;

  logic [MEM_W-1:0]    mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0]   q_addr [$];
  logic [DATA_W:0]     q_xfer [$];
  int                  n_done = 0;
  int                  zero_viol = 0;
  int                  stab_viol = 0;
  int                  pulse_viol = 0;

  word_unpacker #(.DATA_W(DATA_W), .MEM_WORD_SIZE(MEM_W), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .start_addr_i(start_addr),
    .end_addr_i  (end_addr),
    .mem_re_o    (mem_re),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata),
    .data_o      (data),
    .loc_o       (loc),
    .valid_o     (valid),
    .ready_i     (ready),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  // Synchronous read memory: data for a read issued in one cycle is on mem_rdata the next.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= 64'hDEAD_BEEF_DEAD_BEEF;
  end

  // Monitor sampled on the falling edge, away from the active edge.
  logic              p_valid = 1'b0;
  logic              p_ready = 1'b0;
  logic              p_done  = 1'b0;
  logic [DATA_W-1:0] p_data  = '0;
  logic              p_loc   = 1'b0;
  always @(negedge clk) begin
    if (!valid && (data != '0 || loc != 1'b0)) zero_viol++;
    if (!mem_re && mem_addr != '0) zero_viol++;
    if (!rst && p_valid && !p_ready && (!valid || data != p_data || loc != p_loc)) stab_viol++;
    if (done && p_done) pulse_viol++;
    if (mem_re) q_addr.push_back(mem_addr);
    if (valid && ready) q_xfer.push_back({loc, data});
    if (done) n_done++;
    p_valid = valid && !rst;
    p_ready = ready;
    p_done  = done;
    p_data  = data;
    p_loc   = loc;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [MEM_W-1:0] pattern(input int a);
    logic [31:0] av;
    av = 32'(a);
    return {32'hC000_0000 | av, 32'h0000_5000 | av};
  endfunction

  function automatic logic [DATA_W:0] exp_xfer(input logic [ADDR_W-1:0] a, input bit second);
    logic       l;
    logic [63:0] w;
    w = mem[a];
    l = HI_FIRST ^ second;
    return {l, l ? w[63:32] : w[31:0]};
  endfunction

  task automatic clear_mon();
    q_addr.delete();
    q_xfer.delete();
    n_done = 0;
  endtask

  task automatic kick(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
    @(posedge clk) #1;
    start      = 1'b1;
    start_addr = s;
    end_addr   = e;
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int i;
    for (i = 0; i < max_cyc && n_done == 0; i++) @(posedge clk) #1;
    if (n_done == 0) check({tag, "_timeout"}, 64'(i), 64'(max_cyc + 1));
    repeat (2) @(posedge clk) #1;
  endtask

  task automatic check_run(input string tag, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
    logic [ADDR_W-1:0] a;
    int n;
    n = 1;
    a = s;
    while (a != e) begin a = a + 1'b1; n++; end
    check({tag, "_nreads"}, 64'(q_addr.size()), 64'(n));
    check({tag, "_nxfers"}, 64'(q_xfer.size()), 64'(2 * n));
    check({tag, "_ndone"}, 64'(n_done), 64'd1);
    a = s;
    for (int k = 0; k < n; k++) begin
      if (k < q_addr.size()) check({tag, "_addr"}, 64'(q_addr[k]), 64'(a));
      if (2 * k + 1 < q_xfer.size()) begin
        check({tag, "_xfer0"}, 64'(q_xfer[2 * k]),     64'(exp_xfer(a, 1'b0)));
        check({tag, "_xfer1"}, 64'(q_xfer[2 * k + 1]), 64'(exp_xfer(a, 1'b1)));
      end
      a = a + 1'b1;
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int i;
    logic [DATA_W-1:0] held;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = pattern(a);
    mem[0] = 64'hAAAA_BBBB_1111_2222;
    rst = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0; ready = 1'b0;

    #1;
    check("reset_outs", {57'd0, mem_re, mem_addr != '0, data != '0, loc, valid, busy, done}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single word at address 0, cycle-by-cycle latency.
    ready = 1'b1;
    clear_mon();
    @(posedge clk) #1;
    start = 1'b1; start_addr = 10'd0; end_addr = 10'd0;
    @(posedge clk) #1;
    start = 1'b0;
    @(negedge clk);
    check("lat_re",    {mem_re, busy, valid}, 3'b110);
    @(negedge clk);
    check("lat_wait",  {mem_re, busy, valid}, 3'b010);
    @(negedge clk);
    check("lat_first", {valid, loc, data}, HI_FIRST ? {2'b11, 32'hAAAA_BBBB} : {2'b10, 32'h1111_2222});
    @(negedge clk);
    check("lat_second", {valid, loc, data}, HI_FIRST ? {2'b10, 32'h1111_2222} : {2'b11, 32'hAAAA_BBBB});
    @(negedge clk);
    check("lat_done",  {done, valid, busy}, 3'b101);
    @(negedge clk);
    check("lat_idle",  {done, busy}, 2'b00);
    check_run("w0", 10'd0, 10'd0);

    // Three words; start is held with a different address while busy and must be ignored.
    clear_mon();
    @(posedge clk) #1;
    start = 1'b1; start_addr = 10'd4; end_addr = 10'd6;
    @(posedge clk) #1;
    start_addr = 10'd9; end_addr = 10'd9;
    repeat (3) @(posedge clk) #1;
    start = 1'b0;
    wait_done("run4", 100);
    check_run("run4", 10'd4, 10'd6);

    // Consumer stall in the first send state.
    ready = 1'b0;
    clear_mon();
    kick(10'd7, 10'd7);
    for (i = 0; i < 20 && !valid; i++) @(posedge clk) #1;
    check("stall_valid", 64'(valid), 64'd1);
    held = data;
    repeat (5) @(posedge clk) #1;
    check("stall_hold", {valid, loc, data}, {1'b1, exp_xfer(10'd7, 1'b0)});
    check("stall_same", 64'(data), 64'(held));
    check("stall_reads", 64'(q_addr.size()), 64'd1);
    ready = 1'b1;
    wait_done("stall", 50);
    check_run("stall", 10'd7, 10'd7);

    // Address wrap through the top of the address space.
    clear_mon();
    kick(10'd1023, 10'd1);
    wait_done("wrap", 100);
    check_run("wrap", 10'd1023, 10'd1);

    // Asynchronous reset while in the second send state.
    clear_mon();
    kick(10'd3, 10'd3);
    for (i = 0; i < 20 && !(valid && loc == !HI_FIRST); i++) @(negedge clk);
    check("abort_second", {valid, loc}, {1'b1, !HI_FIRST});
    ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("abort_outs", {57'd0, mem_re, mem_addr != '0, data != '0, loc, valid, busy, done}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk) #1;
    check("abort_nodone", 64'(n_done), 64'd0);
    ready = 1'b1;
    clear_mon();
    kick(10'd2, 10'd2);
    wait_done("fresh", 50);
    check_run("fresh", 10'd2, 10'd2);

    check("zero_when_idle", 64'(zero_viol), 64'd0);
    check("stable_stall", 64'(stab_viol), 64'd0);
    check("done_pulse", 64'(pulse_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/word_unpacker.md
WORD_UNPACKER -- requirements
Module: word_unpacker

Interface
REQ-001 Parameter DATA_W, default 32, width of one operand/result half.
REQ-002 Parameter MEM_WORD_SIZE, default 64, memory word width; SHALL equal 2*DATA_W.
REQ-003 Parameter ADDR_W, default 10, memory word-address width.
REQ-004 clk_i  input  1  single clock; all state updates on posedge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 start_i  input  1  begin a read run; sampled only in IDLE.
REQ-007 start_addr_i  input  ADDR_W  first word address of run.
REQ-008 end_addr_i  input  ADDR_W  last word address of run (inclusive).
REQ-009 mem_re_o  output  1  memory read enable, one-cycle pulse per word.
REQ-010 mem_addr_o  output  ADDR_W  memory read address.
REQ-011 mem_rdata_i  input  MEM_WORD_SIZE  read data, valid the cycle after mem_re_o.
REQ-012 data_o  output  DATA_W  unpacked half-word to consumer.
REQ-013 loc_o  output  1  half being presented: 0 = bits [DATA_W-1:0], 1 = bits [MEM_WORD_SIZE-1:DATA_W].
REQ-014 valid_o  output  1  data_o/loc_o valid.
REQ-015 ready_i  input  1  consumer accepts; transfer when valid_o & ready_i.
REQ-016 busy_o  output  1  high in every state except IDLE.
REQ-017 done_o  output  1  one-cycle pulse at run completion.

Function
REQ-018 FSM states SHALL be IDLE, READ, WAIT, SEND_FIRST, SEND_SECOND, DONE.
REQ-019 IDLE: start_i=1 latches start_addr_i into cur_addr and end_addr_i into last_addr, next state READ; start_i ignored in all other states.
REQ-020 READ: mem_re_o=1, mem_addr_o=cur_addr for exactly one cycle, next WAIT.
REQ-021 WAIT: mem_rdata_i captured into a MEM_WORD_SIZE word register at end of cycle, next SEND_FIRST.
REQ-022 SEND_FIRST: valid_o=1, low half, loc_o=0; stays until ready_i=1, then SEND_SECOND.
REQ-023 SEND_SECOND: valid_o=1, high half, loc_o=1; on ready_i=1: if cur_addr==last_addr go DONE, else cur_addr<=cur_addr+1 and go READ.
REQ-024 DONE: done_o=1 for one cycle, next IDLE.
REQ-025 Latency: start_i accepted at edge N -> mem_re_o high cycle N+1 -> valid_o first high cycle N+3, with ready_i held high.
REQ-026 data_o and loc_o SHALL be stable while valid_o=1 and ready_i=0; valid_o SHALL NOT drop before transfer.
REQ-027 data_o=0, loc_o=0, mem_addr_o=0 whenever corresponding valid/enable is low.
REQ-028 cur_addr increments modulo 2^ADDR_W; start_addr_i>end_addr_i wraps through max address to end_addr_i.
REQ-029 start_addr_i==end_addr_i SHALL produce exactly one word (two transfers).
REQ-030 ready_i asserted outside SEND states SHALL have no effect.

Reset
REQ-031 rst_i=1 SHALL immediately, without clock, force IDLE and clear cur_addr, last_addr, word register.
REQ-032 During reset all outputs SHALL be 0.
REQ-033 Reset mid-run SHALL abort with no done_o pulse; a new start_i after release begins a fresh run.

Configuration
REQ-034 Macro WORD_UNPACKER_HI_FIRST_EN: defined -> SEND_FIRST presents high half (loc_o=1) and SEND_SECOND low half (loc_o=0); undefined -> low half first per REQ-022/023.

Verification
REQ-035 start 0..0, mem[0]=64'hAAAA_BBBB_1111_2222, ready_i=1 -> data_o 32'h1111_2222 (loc 0) then 32'hAAAA_BBBB (loc 1), done_o one cycle later, valid_o first high 3 cycles after start.
REQ-036 start 4..6, ready_i=1 -> mem_addr_o 4,5,6 in order, six transfers, single done_o.
REQ-037 ready_i low for 5 cycles during SEND_FIRST -> data_o, loc_o, valid_o held constant, no extra mem_re_o.
REQ-038 start_addr 1023, end_addr 1 (ADDR_W=10) -> addresses 1023,0,1, six transfers.
REQ-039 rst_i asserted mid-SEND_SECOND between clock edges -> outputs 0 immediately, no done_o; subsequent start 2..2 completes normally.
REQ-040 WORD_UNPACKER_HI_FIRST_EN defined, REQ-035 stimulus -> 32'hAAAA_BBBB (loc 1) first, then 32'h1111_2222 (loc 0).
